fb_port_arbiter: RTL and testbench
==================================

# fb_port_arbiter

Round-robin arbiter sharing the single frame-buffer memory port among up to NUM_REQ drawing engines (line, circle, fill, blit), each exposing the engine-side arbiter interface: rts/rtr, 17-bit address, 32-bit write data, 4-bit write op and a broadcast read-return strobe. It sits between the engines' read-modify-write stages and the frame-buffer controller. It optionally locks the port to one engine across a read-modify-write pair so that overlapping pixel words are never corrupted.

## Interface
- NUM_REQ, 4: number of requesting engines, 2..8.
- PTR_W, 2: width of the round-robin pointer and owner index, equal to ceil(log2(NUM_REQ)).
- clk  input  1  clock; all state changes on its rising edge.
- rst_  input  1  reset, asynchronous and active-low.
- req_rts  input  NUM_REQ  per-engine request valid.
- req_rtr  output  NUM_REQ  per-engine accept; at most one bit high.
- req_addr  input  NUM_REQ*17  flattened word addresses; engine i uses bits [17i+16:17i].
- req_data  input  NUM_REQ*32  flattened write data.
- req_wr_op  input  NUM_REQ*4  flattened byte write enables; 4'b0000 means read.
- bcast_xfc  output  NUM_REQ  one-hot read-return strobe.
- arb_data_out  output  32  read-return data, common to all engines.
- mem_rts  output  1  request to memory.
- mem_rtr  input  1  memory accepts request.
- mem_addr  output  17  muxed address.
- mem_wdata  output  32  muxed write data.
- mem_wr_op  output  4  muxed write op.
- mem_rdata  input  32  read data.
- mem_rvalid  input  1  one-cycle pulse, read data valid.

## Operation
- States: IDLE, READ_WAIT, LOCKED.
- IDLE: the winner is the first i with req_rts[i]=1, searching from ptr upward modulo NUM_REQ.
  - mem_rts = req_rts[winner]. mem_addr, mem_wdata and mem_wr_op are muxed from the winner. req_rtr[winner] = mem_rtr; all other req_rtr bits are 0.
  - If no engine requests, mem_rts = 0 and the mem_* data outputs hold their last muxed value.
- A transfer occurs when mem_rts and mem_rtr are both 1.
  - Write transfer in IDLE: ptr <= winner+1 mod NUM_REQ; state stays IDLE.
  - Read transfer: owner <= winner; go to READ_WAIT.
- READ_WAIT: mem_rts = 0 and all req_rtr = 0. On mem_rvalid, capture mem_rdata and go to LOCKED (lock enabled) or IDLE with ptr <= owner+1 (lock disabled).
- Read return: arb_data_out <= mem_rdata and bcast_xfc[owner] <= 1 for exactly one cycle, both registered. arb_data_out holds its value until the next return.
- LOCKED: only the owner is eligible; the other engines are masked.
  - Owner write transfer: go to IDLE with ptr <= owner+1.
  - Owner read transfer: go to READ_WAIT again; the lock is retained.
- Boundary conditions:
  - mem_rvalid in IDLE or LOCKED is ignored: no bcast_xfc.
  - ptr wraps from NUM_REQ-1 to 0.
  - All engines requesting continuously are served in order ptr, ptr+1, …; each waits at most NUM_REQ-1 grants.
  - A requester dropping rts before acceptance is legal; the winner is recomputed each cycle in IDLE.
  - Reset mid-operation returns to IDLE and discards any pending read return; no bcast_xfc is issued.

## Timing
- Reset values: req_rtr = 0, bcast_xfc = 0, arb_data_out = 0, mem_rts = 0, mem_addr = 0, mem_wdata = 0, mem_wr_op = 0, ptr = 0, owner = 0, state = IDLE.
- The request path is combinational: zero cycles from req_rts to mem_rts.
- Read return: bcast_xfc rises one cycle after mem_rvalid.
- One outstanding read at most. Minimum read turnaround for the next grant is 1 cycle after the mem_rvalid cycle.
- A write by a different engine can be accepted every cycle when mem_rtr = 1.

## Configuration
- FB_ARB_RMW_LOCK_EN defined: LOCKED state is present and a read grants the port exclusively to that engine until its next write transfer.
- FB_ARB_RMW_LOCK_EN undefined: LOCKED is removed and READ_WAIT always returns to IDLE with ptr <= owner+1. Read return and one-outstanding-read behaviour are unchanged.

## Test plan
- Reset, then all req_rts = 4'b1111, all writes, mem_rtr = 1 -> grants 0,1,2,3,0 on consecutive cycles; mem_addr follows the granted engine.
- Engine 2 reads addr 17'h00A10 and memory returns 32'hDEADBEEF three cycles later -> bcast_xfc = 4'b0100 for one cycle, one cycle after mem_rvalid; arb_data_out = 32'hDEADBEEF.
- Lock enabled: engine 1 reads, engines 0 and 3 request writes during READ_WAIT and LOCKED, engine 1 then writes -> engine 1's write is the next transfer, then engine 3, then engine 0.
- Lock disabled, same stimulus -> after the read return, engine 3 is granted before engine 1's write.
- mem_rtr held 0 for 5 cycles with engine 0 requesting -> req_rtr stays 0 and mem_rts stays 1 with stable mem_addr; the transfer occurs on the first cycle mem_rtr = 1.
- rst_ asserted during READ_WAIT, then a late mem_rvalid -> bcast_xfc stays 0, state is IDLE, ptr = 0.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// Round-robin arbiter sharing the frame-buffer memory port among NUM_REQ drawing engines.
// Define FB_ARB_RMW_LOCK_EN to hold the port for a read's owner until its next write (RMW lock).
module fb_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NUM_REQ-1:0]     req_rts,
    output logic [NUM_REQ-1:0]     req_rtr,
    input  logic [NUM_REQ*17-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_data,
    input  logic [NUM_REQ*4-1:0]   req_wr_op,
    output logic [NUM_REQ-1:0]     bcast_xfc,
    output logic [31:0]            arb_data_out,
    output logic                   mem_rts,
    input  logic                   mem_rtr,
    output logic [16:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_wr_op,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_rvalid
);

    // state     | meaning
    // IDLE      | round-robin arbitration among all requesters
    // READ_WAIT | one read outstanding, port blocked until mem_rvalid
    // LOCKED    | read data returned, only the owner may use the port
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1
`ifdef FB_ARB_RMW_LOCK_EN
        , LOCKED  = 2'd2
`endif
    } state_t;

    state_t             state, state_nx;
    logic [PTR_W-1:0]   ptr, ptr_nx;
    logic [PTR_W-1:0]   owner, owner_nx;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   idx_w;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] owner_mask;
    logic               found;
    logic               xfer;
    logic               is_read;
    logic               ret;
    int                 idx;

    logic [16:0] addr_arr  [NUM_REQ];
    logic [31:0] data_arr  [NUM_REQ];
    logic [3:0]  op_arr    [NUM_REQ];
    logic [16:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wr_op_q;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[17*i +: 17];
            data_arr[i] = req_data[32*i +: 32];
            op_arr[i]   = req_wr_op[4*i +: 4];
        end
    end

    assign owner_mask = NUM_REQ'(1) << owner;

    always_comb begin
        elig = '0;
        case (state)
            IDLE:    elig = req_rts;
`ifdef FB_ARB_RMW_LOCK_EN
            LOCKED:  elig = req_rts & owner_mask;
`endif
            default: elig = '0;
        endcase
    end

    // Search starts at ptr and wraps, so the last-served engine has lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = 0;
        idx_w  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = idx[PTR_W-1:0];
            if (!found && elig[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

    always_comb begin
        mem_rts   = found;
        mem_addr  = found ? addr_arr[winner] : addr_q;
        mem_wdata = found ? data_arr[winner] : wdata_q;
        mem_wr_op = found ? op_arr[winner]   : wr_op_q;
        req_rtr   = (found && mem_rtr) ? (NUM_REQ'(1) << winner) : '0;
    end

    assign xfer    = found & mem_rtr;
    assign is_read = (mem_wr_op == 4'b0000);
    assign ret     = (state == READ_WAIT) && mem_rvalid;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (is_read) begin
                        owner_nx = winner;
                        state_nx = READ_WAIT;
                    end else begin
                        ptr_nx = inc_ptr(winner);
                    end
                end
            end
            READ_WAIT: begin
                if (mem_rvalid) begin
`ifdef FB_ARB_RMW_LOCK_EN
                    state_nx = LOCKED;
`else
                    state_nx = IDLE;
                    ptr_nx   = inc_ptr(owner);
`endif
                end
            end
`ifdef FB_ARB_RMW_LOCK_EN
            LOCKED: begin
                if (xfer) begin
                    if (is_read) begin
                        state_nx = READ_WAIT;
                    end else begin
                        state_nx = IDLE;
                        ptr_nx   = inc_ptr(owner);
                    end
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_op_q      <= '0;
            bcast_xfc    <= '0;
            arb_data_out <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            owner     <= owner_nx;
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            wr_op_q   <= mem_wr_op;
            bcast_xfc <= ret ? owner_mask : '0;
            if (ret) begin
                arb_data_out <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed self-checking bench for fb_port_arbiter (NUM_REQ = 4); expectations follow FB_ARB_RMW_LOCK_EN.
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_;
    logic [3:0]  req_rts;
    logic [3:0]  req_rtr;
    logic [67:0] req_addr;
    logic [127:0] req_data;
    logic [15:0] req_wr_op;
    logic [3:0]  bcast_xfc;
    logic [31:0] arb_data_out;
    logic        mem_rts;
    logic        mem_rtr;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wr_op;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fb_port_arbiter #(.NUM_REQ(4), .PTR_W(2)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .req_rts      (req_rts),
        .req_rtr      (req_rtr),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_wr_op    (req_wr_op),
        .bcast_xfc    (bcast_xfc),
        .arb_data_out (arb_data_out),
        .mem_rts      (mem_rts),
        .mem_rtr      (mem_rtr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wr_op    (mem_wr_op),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid)
    );

    task automatic set_eng(input int i, input logic rts, input logic [16:0] a,
                           input logic [31:0] d, input logic [3:0] op);
        req_rts[i]            = rts;
        req_addr[17*i +: 17]  = a;
        req_data[32*i +: 32]  = d;
        req_wr_op[4*i +: 4]   = op;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_       = 1'b1;
        req_rts    = '0;
        req_addr   = '0;
        req_data   = '0;
        req_wr_op  = '0;
        mem_rtr    = 1'b1;
        mem_rdata  = '0;
        mem_rvalid = 1'b0;
        #2 rst_ = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (req_rtr !== 4'b0000 || bcast_xfc !== 4'b0000 || mem_rts !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: req_rtr=%b bcast=%b mem_rts=%b expected 0000 0000 0", req_rtr, bcast_xfc, mem_rts);
        end
        tests_run++;
        if (arb_data_out !== 32'h0 || mem_addr !== 17'h0 || mem_wdata !== 32'h0 || mem_wr_op !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_data: arb=%h addr=%h wdata=%h op=%h expected all 0", arb_data_out, mem_addr, mem_wdata, mem_wr_op);
        end
        rst_ = 1'b1;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        int e;
        step;
        for (int i = 0; i < 4; i++) set_eng(i, 1'b1, 17'h00100 + 17'(i), 32'hC0DE0000 + 32'(i), 4'hF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            e = k % 4;
            exp_g = 4'b0001 << e;
            tests_run++;
            if (req_rtr !== exp_g || mem_addr !== 17'h00100 + 17'(e) || mem_wdata !== 32'hC0DE0000 + 32'(e)) begin
                tests_failed++;
                $display("FAIL rr_grant[%0d]: req_rtr=%b addr=%h wdata=%h expected %b %h %h", k, req_rtr, mem_addr, mem_wdata,
                         exp_g, 17'h00100 + 17'(e), 32'hC0DE0000 + 32'(e));
            end
            step;
        end
        req_rts = '0;
    endtask

    task automatic test_read_return;
        set_eng(2, 1'b1, 17'h00A10, 32'h0, 4'h0);
        @(negedge clk);
        tests_run++;
        if (req_rtr !== 4'b0100 || mem_addr !== 17'h00A10 || mem_wr_op !== 4'h0) begin
            tests_failed++;
            $display("FAIL rd_grant: req_rtr=%b addr=%h op=%h expected 0100 00a10 0", req_rtr, mem_addr, mem_wr_op);
        end
        step;
        set_eng(2, 1'b0, 17'h00A10, 32'h0, 4'h0);
        step;
        step;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        tests_run++;
        if (bcast_xfc !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rd_early_bcast: bcast=%b expected 0000", bcast_xfc);
        end
        step;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        @(negedge clk);
        tests_run++;
        if (bcast_xfc !== 4'b0100 || arb_data_out !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL rd_return: bcast=%b data=%h expected 0100 deadbeef", bcast_xfc, arb_data_out);
        end
        step;
        @(negedge clk);
        tests_run++;
        if (bcast_xfc !== 4'b0000 || arb_data_out !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL rd_pulse_width: bcast=%b data=%h expected 0000 deadbeef", bcast_xfc, arb_data_out);
        end
        // Engine 2 completes its RMW with a write; same outcome with or without the lock.
        step;
        set_eng(2, 1'b1, 17'h00A10, 32'h00000077, 4'hF);
        @(negedge clk);
        tests_run++;
        if (req_rtr !== 4'b0100 || mem_wr_op !== 4'hF) begin
            tests_failed++;
            $display("FAIL rmw_write: req_rtr=%b op=%h expected 0100 f", req_rtr, mem_wr_op);
        end
        step;
        set_eng(2, 1'b0, 17'h00A10, 32'h00000077, 4'hF);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BADF00D;
        step;
        mem_rvalid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bcast_xfc !== 4'b0000 || arb_data_out !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL stray_rvalid: bcast=%b data=%h expected 0000 deadbeef", bcast_xfc, arb_data_out);
        end
    endtask

    function automatic logic [16:0] lock_addr(input int e);
        case (e)
            0:       return 17'h00200;
            1:       return 17'h00111;
            default: return 17'h00203;
        endcase
    endfunction

    task automatic test_lock;
        int seq [3];
        logic [3:0] exp_g;
`ifdef FB_ARB_RMW_LOCK_EN
        seq = '{1, 3, 0};
`else
        seq = '{3, 0, 1};
`endif
        step;
        set_eng(1, 1'b1, 17'h00111, 32'h0, 4'h0);
        @(negedge clk);
        tests_run++;
        if (req_rtr !== 4'b0010) begin
            tests_failed++;
            $display("FAIL lock_rd_grant: req_rtr=%b expected 0010", req_rtr);
        end
        step;
        set_eng(1, 1'b0, 17'h00111, 32'h0, 4'h0);
        set_eng(0, 1'b1, 17'h00200, 32'h000000A0, 4'hF);
        set_eng(3, 1'b1, 17'h00203, 32'h000000A3, 4'hF);
        @(negedge clk);
        tests_run++;
        if (mem_rts !== 1'b0 || req_rtr !== 4'b0000) begin
            tests_failed++;
            $display("FAIL read_wait_mask: mem_rts=%b req_rtr=%b expected 0 0000", mem_rts, req_rtr);
        end
        step;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        step;
        mem_rvalid = 1'b0;
        set_eng(1, 1'b1, 17'h00111, 32'h000000A1, 4'hF);
        @(negedge clk);
        tests_run++;
        if (bcast_xfc !== 4'b0010 || arb_data_out !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL lock_return: bcast=%b data=%h expected 0010 12345678", bcast_xfc, arb_data_out);
        end
        for (int k = 0; k < 3; k++) begin
            exp_g = 4'b0001 << seq[k];
            tests_run++;
            if (req_rtr !== exp_g || mem_addr !== lock_addr(seq[k])) begin
                tests_failed++;
                $display("FAIL lock_order[%0d]: req_rtr=%b addr=%h expected %b %h", k, req_rtr, mem_addr, exp_g, lock_addr(seq[k]));
            end
            step;
            req_rts[seq[k]] = 1'b0;
            @(negedge clk);
        end
        tests_run++;
        if (mem_rts !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_drain: mem_rts=%b expected 0", mem_rts);
        end
    endtask

    task automatic test_backpressure;
        step;
        mem_rtr = 1'b0;
        set_eng(0, 1'b1, 17'h1ABCD, 32'h55AA55AA, 4'h3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests_run++;
            if (req_rtr !== 4'b0000 || mem_rts !== 1'b1 || mem_addr !== 17'h1ABCD) begin
                tests_failed++;
                $display("FAIL bp_stall[%0d]: req_rtr=%b mem_rts=%b addr=%h expected 0000 1 1abcd", k, req_rtr, mem_rts, mem_addr);
            end
            step;
        end
        mem_rtr = 1'b1;
        @(negedge clk);
        tests_run++;
        if (req_rtr !== 4'b0001) begin
            tests_failed++;
            $display("FAIL bp_accept: req_rtr=%b expected 0001", req_rtr);
        end
        step;
        set_eng(0, 1'b0, 17'h1ABCD, 32'h55AA55AA, 4'h3);
        @(negedge clk);
        tests_run++;
        if (mem_rts !== 1'b0 || mem_addr !== 17'h1ABCD || mem_wdata !== 32'h55AA55AA || mem_wr_op !== 4'h3) begin
            tests_failed++;
            $display("FAIL idle_hold: mem_rts=%b addr=%h wdata=%h op=%h expected 0 1abcd 55aa55aa 3", mem_rts, mem_addr, mem_wdata, mem_wr_op);
        end
    endtask

    task automatic test_reset_mid_read;
        step;
        set_eng(3, 1'b1, 17'h00333, 32'h0, 4'h0);
        @(negedge clk);
        tests_run++;
        if (req_rtr !== 4'b1000) begin
            tests_failed++;
            $display("FAIL mid_rd_grant: req_rtr=%b expected 1000", req_rtr);
        end
        step;
        set_eng(3, 1'b0, 17'h00333, 32'h0, 4'h0);
        set_eng(0, 1'b1, 17'h00044, 32'h00000044, 4'hF);
        @(negedge clk);
        tests_run++;
        if (mem_rts !== 1'b0 || req_rtr !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_rd_wait: mem_rts=%b req_rtr=%b expected 0 0000", mem_rts, req_rtr);
        end
        #1 rst_ = 1'b0;
        set_eng(0, 1'b0, 17'h00044, 32'h00000044, 4'hF);
        step;
        @(negedge clk);
        rst_ = 1'b1;
        step;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        step;
        mem_rvalid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bcast_xfc !== 4'b0000 || arb_data_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL late_rvalid: bcast=%b data=%h expected 0000 00000000", bcast_xfc, arb_data_out);
        end
        step;
        for (int i = 0; i < 4; i++) set_eng(i, 1'b1, 17'h00100 + 17'(i), 32'h0, 4'hF);
        @(negedge clk);
        tests_run++;
        if (req_rtr !== 4'b0001 || mem_addr !== 17'h00100) begin
            tests_failed++;
            $display("FAIL post_reset_ptr: req_rtr=%b addr=%h expected 0001 00100", req_rtr, mem_addr);
        end
        step;
        req_rts = '0;
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_read_return;
        test_lock;
        test_backpressure;
        test_reset_mid_read;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
